// File: rtl/mod_sysbus_mem.sv
`default_nettype none
// ============================================================================
// Module   : mod_sysbus_mem
// Brief    : Sysbus cache-line memory responder. Accepts line-aligned read and
//            write requests and moves 64-byte lines as eight 64-bit beats
//            to/from an internal word array.
// Revision : 1.0 - initial release
// ============================================================================
module mod_sysbus_mem #(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int MEM_WORDS    = 65536,
    parameter int READ_LATENCY = 4,
    parameter int LINE_BEATS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqcyc,
    input  logic [DATA_WIDTH-1:0] req,
    input  logic [TAG_WIDTH-1:0]  reqtag,
    output logic                  reqack,
    output logic                  respcyc,
    output logic [DATA_WIDTH-1:0] resp,
    output logic [TAG_WIDTH-1:0]  resptag,
    input  logic                  respack
);

    // Word index = {line, beat}; keeping only the low line bits gives the
    // modulo-MEM_WORDS wrap for free.
    localparam int         c_ADDR_W    = $clog2(MEM_WORDS);
    localparam int         c_LINE_W    = c_ADDR_W - 3;
    localparam int         c_LAT_W     = $clog2(READ_LATENCY + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(READ_LATENCY);
    localparam logic [2:0] c_LAST_BEAT = 3'(LINE_BEATS - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_RD_BURST = 3'd2;
    localparam logic [2:0] c_ST_WR_DATA  = 3'd3;
    localparam logic [2:0] c_ST_WR_RESP  = 3'd4;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [2:0]            r_state;
    logic [c_LINE_W-1:0]   r_line;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [2:0]            r_beat;
    logic [c_LAT_W-1:0]    r_lat;
    logic                  r_reqack;
    logic                  r_respcyc;
    logic [DATA_WIDTH-1:0] r_resp;
    logic [TAG_WIDTH-1:0]  r_resptag;

    logic [2:0]            w_rd_beat;
    logic [c_ADDR_W-1:0]   w_rd_idx;
    logic [c_ADDR_W-1:0]   w_wr_idx;
    logic                  w_wr_en;

    // The read port looks one beat ahead during a burst so the next word is
    // registered on the same edge that accepts the current one.
    assign w_rd_beat = (r_state == c_ST_RD_BURST) ? (r_beat + 3'd1) : 3'd0;
    assign w_rd_idx  = {r_line, w_rd_beat};
    assign w_wr_idx  = {r_line, r_beat};
    // A held write beat is taken only once: the ack-high cycle blocks capture.
    assign w_wr_en   = (r_state == c_ST_WR_DATA) && reqcyc && !r_reqack;

    // Backing store write port; never reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= req;
        end
    end

    // Transaction sequencer: request capture, read latency/burst, write beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_line    <= '0;
            r_tag     <= '0;
            r_beat    <= 3'd0;
            r_lat     <= '0;
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
            r_resptag <= '0;
        end else begin
            r_reqack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (reqcyc) begin
                        r_line   <= req[c_LINE_W+5:6];
                        r_tag    <= reqtag;
                        r_reqack <= 1'b1;
                        r_beat   <= 3'd0;
                        if (reqtag[0]) begin
                            r_lat   <= c_LAT_INIT;
                            r_state <= c_ST_RD_WAIT;
                        end else begin
                            r_state <= c_ST_WR_DATA;
                        end
                    end
                end
                c_ST_RD_WAIT: begin
                    if (r_lat == '0) begin
                        r_respcyc <= 1'b1;
                        r_resp    <= r_mem[w_rd_idx];
                        r_resptag <= r_tag;
                        r_state   <= c_ST_RD_BURST;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                c_ST_RD_BURST: begin
                    if (respack) begin
                        if (r_beat == c_LAST_BEAT) begin
                            r_respcyc <= 1'b0;
                            r_resp    <= '0;
                            r_resptag <= '0;
                            r_beat    <= 3'd0;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                            r_resp <= r_mem[w_rd_idx];
                        end
                    end
                end
                c_ST_WR_DATA: begin
                    if (w_wr_en) begin
                        r_reqack <= 1'b1;
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat  <= 3'd0;
                            r_state <= c_ST_WR_RESP;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                c_ST_WR_RESP: begin
                    if (!r_respcyc) begin
                        r_respcyc <= 1'b1;
                        r_resp    <= '0;
                        r_resptag <= r_tag;
                    end else if (respack) begin
                        r_respcyc <= 1'b0;
                        r_resptag <= '0;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign reqack  = r_reqack;
    assign respcyc = r_respcyc;
    assign resp    = r_resp;
    assign resptag = r_resptag;

endmodule
`default_nettype wire

// File: tb/tb_mod_sysbus_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_sysbus_mem
// Brief    : Scoreboard bench for mod_sysbus_mem (64-word store, latency 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_sysbus_mem;

    localparam int c_WORDS = 64;
    localparam int c_LAT   = 4;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
        int          beat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [63:0] model_mem [c_WORDS];
    int          pops       = 0;
    int          hold_cnt   = 0;
    int          beat2_hold = 0;
    bit          bp_en      = 1'b0;
    int          bp_left    = 0;

    mod_sysbus_mem #(
        .DATA_WIDTH  (64),
        .TAG_WIDTH   (13),
        .MEM_WORDS   (c_WORDS),
        .READ_LATENCY(c_LAT),
        .LINE_BEATS  (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .reqcyc (reqcyc),
        .req    (req),
        .reqtag (reqtag),
        .reqack (reqack),
        .respcyc(respcyc),
        .resp   (resp),
        .resptag(resptag),
        .respack(respack)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    // Reference word index: line-granular address, wrapped into the store.
    function automatic int widx(input logic [63:0] addr, input int b);
        logic [63:0] w;
        w = (addr >> 6) * 64'd8 + 64'(b);
        return int'(w % 64'(c_WORDS));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT offers a response beat.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset && reqack) chk("no_resp_with_reqack", 64'(respcyc), 64'd0);
            if (reset && respcyc) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got data %0h tag %0h, want none", resp, resptag);
                end else begin
                    hold_cnt++;
                    chk("resp_data", resp, exp_q[0].data);
                    chk("resp_tag", 64'(resptag), 64'(exp_q[0].tag));
                    if (respack) begin
                        if (exp_q[0].beat == 2) beat2_hold = hold_cnt;
                        hold_cnt = 0;
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    endtask

    // Response acceptance: random, or a scripted 3-cycle stall on beat 2.
    task automatic ack_driver();
        int cnt      = 0;
        bit last_acc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (last_acc) cnt++;
            if (!respcyc) cnt = 0;
            if (bp_en && respcyc && cnt == 2 && bp_left > 0) begin
                respack = 1'b0;
                bp_left--;
            end else if (bp_en) begin
                respack = 1'b1;
            end else begin
                respack = ($urandom_range(0, 3) != 0);
            end
            last_acc = respcyc && respack;
        end
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!reqack && n < 100);
        chk(nm, 64'(reqack), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic issue(input logic [63:0] addr, input logic [12:0] tag);
        @(negedge clk);
        req    = addr;
        reqtag = tag;
        reqcyc = 1'b1;
        wait_ack("addr_ack");
    endtask

    task automatic push_read(input logic [63:0] addr, input logic [12:0] tag);
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{data: model_mem[widx(addr, i)], tag: tag, beat: i});
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] d [8], input bit gaps);
        exp_q.push_back('{data: 64'd0, tag: tag, beat: -1});
        issue(addr, tag);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    reqcyc = 1'b0;
                    @(negedge clk);
                end
            end
            req    = d[i];
            reqcyc = 1'b1;
            wait_ack("wr_beat_ack");
            model_mem[widx(addr, i)] = d[i];
        end
        reqcyc = 1'b0;
        @(negedge clk);
        chk("wr_cmpl_rise", 64'(respcyc), 64'd1);
        drain();
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag);
        int n = 0;
        push_read(addr, tag);
        issue(addr, tag);
        reqcyc = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("reqack_one_cycle", 64'(reqack), 64'd0);
        end while (!respcyc && n < 40);
        chk("rd_first_beat_latency", 64'(n), 64'(c_LAT + 1));
        drain();
    endtask

    // Read with reqcyc held high through the burst, carrying a second read.
    task automatic do_busy_read(input logic [63:0] a1, input logic [12:0] t1,
                                input logic [63:0] a2, input logic [12:0] t2);
        int  n = 0;
        int  idle_cnt = 0;
        bit  seen = 1'b0;
        push_read(a1, t1);
        issue(a1, t1);
        req    = a2;
        reqtag = t2;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (reqack) break;
            if (respcyc) seen = 1'b1;
            else if (seen) idle_cnt++;
        end
        chk("busy_ack_seen", 64'(reqack), 64'd1);
        chk("busy_burst_before_ack", 64'(seen), 64'd1);
        chk("busy_ack_gap", 64'(idle_cnt), 64'd1);
        push_read(a2, t2);
        reqcyc = 1'b0;
        @(negedge clk);
        chk("busy_single_pulse", 64'(reqack), 64'd0);
        drain();
    endtask

    initial begin
        logic [63:0] d [8];
        logic [12:0] t;
        logic [63:0] a;
        int          n;
        int          p0;

        reset   = 1'b0;
        reqcyc  = 1'b0;
        req     = '0;
        reqtag  = '0;
        respack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_reqack", 64'(reqack), 64'd0);
        chk("rst_respcyc", 64'(respcyc), 64'd0);
        chk("rst_resp", resp, 64'd0);
        chk("rst_resptag", 64'(resptag), 64'd0);
        reset = 1'b1;

        fork
            monitor();
            ack_driver();
        join_none

        // Give every word a known value before any read.
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 8; i++) d[i] = {$urandom(), $urandom()};
            do_write(64'(l) << 6, 13'h010 + 13'(l * 2), d, 1'b1);
        end

        // Directed write then read of line 0x1000.
        for (int i = 0; i < 8; i++) d[i] = 64'h1111_0000_0000_0000 | 64'(i);
        do_write(64'h1000, 13'h0A2, d, 1'b0);
        do_read(64'h1000, 13'h0A3);

        // Address bits [5:0] are ignored.
        do_read(64'h1038, 13'h0A5);

        // Back-pressure on beat 2.
        bp_en   = 1'b1;
        bp_left = 3;
        do_read(64'h1000, 13'h0A7);
        bp_en = 1'b0;
        chk("bp_beat2_hold_cycles", 64'(beat2_hold), 64'd4);

        // Wrap-around: word index 64 aliases to word 0.
        for (int i = 0; i < 8; i++) d[i] = {$urandom(), $urandom()};
        do_write(64'h200, 13'h0B0, d, 1'b1);
        do_read(64'h0, 13'h0B1);
        chk("wrap_model_word0", model_mem[0], d[0]);

        // Busy rejection.
        do_busy_read(64'h40, 13'h0C1, 64'h80, 13'h0C3);

        // Asynchronous reset in the middle of a read burst.
        push_read(64'h0, 13'h0D1);
        issue(64'h0, 13'h0D1);
        reqcyc = 1'b0;
        p0 = pops;
        n  = 0;
        while (pops < p0 + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midburst_reached", 64'(pops >= p0 + 3), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_respcyc", 64'(respcyc), 64'd0);
        chk("async_rst_resp", resp, 64'd0);
        chk("async_rst_resptag", 64'(resptag), 64'd0);
        chk("async_rst_reqack", 64'(reqack), 64'd0);
        exp_q.delete();
        hold_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_read(64'h1C0, 13'h0D3);

        // Random traffic.
        for (int k = 0; k < 20; k++) begin
            a = {$urandom(), $urandom()};
            t = 13'($urandom());
            if ($urandom_range(0, 1) == 1) begin
                t[0] = 1'b0;
                for (int i = 0; i < 8; i++) d[i] = {$urandom(), $urandom()};
                do_write(a, t, d, 1'b1);
            end else begin
                t[0] = 1'b1;
                do_read(a, t);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
